// File: rtl/pattern_pkg.sv
// rtl/pattern_pkg.sv - shared state encoding and counter helpers for the serial pattern family
package pattern_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int WORD_CNT_W = 16;

  // Word counters stick at all-ones rather than wrapping to zero.
  function automatic logic [WORD_CNT_W-1:0] sat_inc(input logic [WORD_CNT_W-1:0] v);
    return (&v) ? v : v + WORD_CNT_W'(1);
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// rtl/piso_shift_reg.sv - parallel-load shift register with a serial tap
//  clk, reset_n : clock, asynchronous active-low reset
//  load, data   : capture data (load wins over shift)
//  shift        : advance one bit toward the tap
//  tap          : bit currently presented (MSB or LSB end per MSB_FIRST)
module piso_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  output logic             tap
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr <= '0;
    end else if (load) begin
      sr <= data;
    end else if (shift) begin
      if (MSB_FIRST) sr <= {sr[WIDTH-2:0], 1'b0};
      else           sr <= {1'b0, sr[WIDTH-1:1]};
    end
  end

  assign tap = MSB_FIRST ? sr[WIDTH-1] : sr[0];

endmodule

// File: rtl/pattern_bit_serializer.sv
// rtl/pattern_bit_serializer.sv - valid/ready word to 1-bit-per-clock stream for the pattern detectors
//  clk, reset_n          : clock, asynchronous active-low reset
//  in_data, in_valid     : parallel word and its valid
//  in_ready              : word can be accepted this cycle
//  ser_out               : serial bit (IDLE_BIT when idle or in a gap)
//  ser_active            : ser_out carries a data bit
//  word_start            : pulse on the first bit of each word
//  word_count            : words fully shifted out, saturating
module pattern_bit_serializer
  import pattern_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_BIT   = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  ser_out,
  output logic                  ser_active,
  output logic                  word_start,
  output logic [WORD_CNT_W-1:0] word_count
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
  localparam bit              HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [3:0]      GAP_LAST = HAS_GAP ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [3:0]       gap_cnt;
  logic             last_bit;
  logic             gap_done;
  logic             xfer;
  logic             tap;

  assign last_bit = (state == ST_SHIFT) && (bit_cnt == BIT_LAST);
  assign gap_done = (state == ST_GAP) && (gap_cnt == GAP_LAST);

  // Ready opens in IDLE, on the final gap cycle, and on the last data bit
  // when no gap is configured so consecutive words run with no bubble.
  assign in_ready = reset_n && ((state == ST_IDLE) || (last_bit && !HAS_GAP) || gap_done);
  assign xfer     = in_valid && in_ready;

  piso_shift_reg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_piso (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (xfer),
    .shift  (state == ST_SHIFT),
    .data   (in_data),
    .tap    (tap)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      word_count <= '0;
      word_start <= 1'b0;
      ser_active <= 1'b0;
    end else begin
      word_start <= xfer;
      // Next cycle shows data if a word was just loaded or one is still mid-flight.
      ser_active <= xfer || ((state == ST_SHIFT) && !last_bit);
      case (state)
        ST_IDLE: begin
          if (xfer) begin
            state   <= ST_SHIFT;
            bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (last_bit) begin
            word_count <= sat_inc(word_count);
            bit_cnt    <= '0;
            if (HAS_GAP) begin
              state   <= ST_GAP;
              gap_cnt <= '0;
            end else if (xfer) begin
              state <= ST_SHIFT;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_done) begin
            state   <= xfer ? ST_SHIFT : ST_IDLE;
            bit_cnt <= '0;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ser_out = ser_active ? tap : IDLE_BIT;

endmodule

// File: tb/tb_pattern_bit_serializer.sv
// tb/tb_pattern_bit_serializer.sv - scoreboard bench for pattern_bit_serializer
module tb_pattern_bit_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [7:0]  in_data [3];
  logic [2:0]  in_valid;
  wire  [2:0]  in_ready;
  wire  [2:0]  ser_out;
  wire  [2:0]  ser_active;
  wire  [2:0]  word_start;
  wire  [15:0] word_count [3];

  // 0: MSB first, no gap   1: MSB first, gap of 3   2: LSB first, no gap
  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      pattern_bit_serializer #(
        .WIDTH     (8),
        .MSB_FIRST (g == 2 ? 1'b0 : 1'b1),
        .IDLE_BIT  (1'b1),
        .GAP_CYCLES(g == 1 ? 3 : 0)
      ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data[g]),
        .in_valid  (in_valid[g]),
        .in_ready  (in_ready[g]),
        .ser_out   (ser_out[g]),
        .ser_active(ser_active[g]),
        .word_start(word_start[g]),
        .word_count(word_count[g])
      );
    end
  endgenerate

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard entry: {last, start, bit, idx[2:0]}
  logic [5:0]  exp_q [$];
  logic [5:0]  e;
  int          sel       = 0;
  int          cyc       = 0;
  int          last_end  = 0;
  bit          le_valid  = 1'b0;
  int          last_gap  = -1;
  int          run       = 0;
  int          max_run   = 0;
  logic [15:0] exp_wc    = '0;
  logic [3:0]  hist      = 4'hF;
  logic [7:0]  det_mask  = '0;
  logic [15:0] stream    = '0;
  logic        exp_ready;
  int          gpos;

  function automatic logic bit_at(input logic [7:0] w, input int i, input bit msb);
    return msb ? w[7-i] : w[i];
  endfunction

  always @(negedge clk) begin
    #2;
    cyc++;
    hist = {hist[2:0], ser_out[sel]};
    if (ser_active[sel]) begin
      run++;
      if (run > max_run) max_run = run;
      stream = {stream[14:0], ser_out[sel]};
      if (exp_q.size() == 0) begin
        check_eq("unexpected_bit", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("ser_out", ser_out[sel], e[3]);
        check_eq("word_start", word_start[sel], e[4]);
        check_eq("ready_busy", in_ready[sel], e[5] && (sel != 1));
        check_eq("word_count_busy", word_count[sel], exp_wc);
        if (e[4] && le_valid) last_gap = cyc - last_end - 1;
        if (sel == 2 && hist == 4'b0101) det_mask[e[2:0]] = 1'b1;
        if (e[5]) begin
          last_end = cyc;
          le_valid = 1'b1;
          if (exp_wc != 16'hFFFF) exp_wc = exp_wc + 16'd1;
        end
      end
    end else begin
      run = 0;
      gpos = cyc - last_end - 1;
      if (!reset_n)                                 exp_ready = 1'b0;
      else if (sel == 1 && le_valid && gpos < 3)    exp_ready = (gpos == 2);
      else                                          exp_ready = 1'b1;
      check_eq("idle_out", ser_out[sel], 1'b1);
      check_eq("idle_start", word_start[sel], 1'b0);
      check_eq("idle_wc", word_count[sel], exp_wc);
      check_eq("idle_ready", in_ready[sel], exp_ready);
    end
    if (reset_n && in_valid[sel] && in_ready[sel]) begin
      for (int i = 0; i < 8; i++)
        exp_q.push_back({i == 7, i == 0, bit_at(in_data[sel], i, sel != 2), 3'(i)});
    end
  end

  task automatic clear_model();
    exp_q.delete();
    exp_wc   = '0;
    le_valid = 1'b0;
    last_gap = -1;
    max_run  = 0;
    det_mask = '0;
    hist     = 4'hF;
    stream   = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    in_valid = '0;
    clear_model();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge with in_valid still high.
  task automatic send(input logic [7:0] w);
    in_data[sel]  = w;
    in_valid[sel] = 1'b1;
    for (int k = 0; k < 100; k++) begin
      #3;
      if (in_ready[sel]) begin
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    check_eq("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !ser_active[sel]) begin
        repeat (4) @(negedge clk);
        return;
      end
    end
    check_eq("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    in_valid = '0;
    for (int i = 0; i < 3; i++) in_data[i] = '0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_ready", in_ready, 3'b000);
    check_eq("rst_ser_out", ser_out, 3'b111);
    check_eq("rst_active", ser_active, 3'b000);
    check_eq("rst_wc", word_count[0], 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_eq("ready_after_rst", in_ready, 3'b111);
    @(negedge clk);

    // Single word, MSB first
    sel = 0;
    send(8'h05);
    in_valid[0] = 1'b0;
    drain();
    check_eq("t2_stream", stream[7:0], 8'h05);
    check_eq("t2_wc", word_count[0], 16'd1);

    // Back-to-back, no gap
    do_reset();
    send(8'h55);
    send(8'h55);
    in_valid[0] = 1'b0;
    drain();
    check_eq("t3_run", max_run, 16);
    check_eq("t3_gap", last_gap, 0);
    check_eq("t3_wc", word_count[0], 16'd2);

    // Reset during bit 3 of a second word
    do_reset();
    send(8'h81);
    in_valid[0] = 1'b0;
    drain();
    send(8'hA5);
    in_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    clear_model();
    #1;
    check_eq("mid_rst_out", ser_out[0], 1'b1);
    check_eq("mid_rst_active", ser_active[0], 1'b0);
    check_eq("mid_rst_wc", word_count[0], 16'd0);
    check_eq("mid_rst_ready", in_ready[0], 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_eq("t1_ready_release", in_ready[0], 1'b1);
    drain();
    check_eq("t1_wc_after", word_count[0], 16'd0);

    // Gap of three idle cycles
    do_reset();
    sel = 1;
    send(8'hC3);
    send(8'h3C);
    in_valid[1] = 1'b0;
    drain();
    check_eq("t4_gap", last_gap, 3);
    check_eq("t4_wc", word_count[1], 16'd2);

    // LSB first into a 0101 detector
    do_reset();
    sel = 2;
    send(8'hAA);
    in_valid[2] = 1'b0;
    drain();
    check_eq("t5_stream", stream[7:0], 8'h55);
    check_eq("t5_detect", det_mask, 8'hA8);
    check_eq("t5_wc", word_count[2], 16'd1);

    // Backpressure: data changes while not ready, capture at transfer edge only
    do_reset();
    sel = 0;
    send(8'h3C);
    in_data[0]  = 8'h11;
    in_valid[0] = 1'b1;
    repeat (2) @(negedge clk);
    send(8'hE7);
    in_valid[0] = 1'b0;
    drain();
    check_eq("t6_stream", stream[15:0], 16'h3CE7);
    check_eq("t6_wc", word_count[0], 16'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
